// File: rtl/calc_sequenciador_if.sv
// Bus bundle between the host, the program sequencer and the accumulator calculator.
// The slave modport is the sequencer's view; master is the host/calculator side.
interface calc_sequenciador_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [10:0]   wr_data;
  logic          start;
  logic [AW:0]   len;
  logic          clr;
  logic          abort;
  logic [2:0]    calc_codigo;
  logic [7:0]    calc_entrada;
  logic [7:0]    calc_saida;
  logic          busy;
  logic          done;
  logic [7:0]    result;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, clr, abort, calc_saida,
    output calc_codigo, calc_entrada, busy, done, result
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, len, clr, abort, calc_saida,
    input  calc_codigo, calc_entrada, busy, done, result
  );
endinterface

// File: rtl/calc_sequenciador.sv
// Replays a small {codigo, entrada} program into the accumulator calculator,
// optionally zeroing the accumulator first, then reads back the final value.
module calc_sequenciador #(
  parameter int AW = 4
) (
  input logic                 clk,
  input logic                 rst,
  calc_sequenciador_if.slave  bus
);
  localparam int          DEPTH  = 2 ** AW;
  localparam logic [AW:0] MAXLEN = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_RD,
    S_CLR_WT,
    S_CLR_SUB,
    S_RUN,
    S_FIN_RD,
    S_FIN_WT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [10:0] r_mem [DEPTH];
  logic [AW:0] r_pc;
  logic [AW:0] r_len;
  logic [2:0]  r_codigo;
  logic [7:0]  r_entrada;
  logic [7:0]  r_result;
  logic        r_done;

  logic [AW:0] w_lenSat;
  logic        w_memWe;
  logic [10:0] w_firstWord;
  logic [10:0] w_pcWord;

  assign w_lenSat    = (bus.len > MAXLEN) ? MAXLEN : bus.len;
  assign w_memWe     = (r_state == S_IDLE) && bus.wr_en;
  assign w_firstWord = r_mem[0];
  assign w_pcWord    = r_mem[r_pc[AW-1:0]];

  // Program memory survives reset; it only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_codigo  <= 3'b000;
      r_entrada <= 8'd0;
      r_done    <= 1'b0;
      r_result  <= 8'd0;
      r_pc      <= '0;
      r_len     <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_codigo  <= 3'b000;
        r_entrada <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_codigo  <= 3'b000;
            r_entrada <= 8'd0;
            if (bus.start) begin
              r_len <= w_lenSat;
              r_pc  <= '0;
              if (bus.clr) begin
                r_state  <= S_CLR_RD;
                r_codigo <= 3'b011;
              end else if (w_lenSat != '0) begin
                r_state                <= S_RUN;
                {r_codigo, r_entrada}  <= w_firstWord;
                r_pc                   <= (AW + 1)'(1);
              end else begin
                r_state  <= S_FIN_RD;
                r_codigo <= 3'b011;
              end
            end
          end
          S_CLR_RD: begin
            r_state   <= S_CLR_WT;
            r_codigo  <= 3'b111;
            r_entrada <= 8'd0;
          end
          // The read-back value lands on saida now; subtracting it zeroes the accumulator.
          S_CLR_WT: begin
            r_state   <= S_CLR_SUB;
            r_codigo  <= 3'b010;
            r_entrada <= bus.calc_saida;
          end
          S_CLR_SUB: begin
            if (r_len != '0) begin
              r_state               <= S_RUN;
              {r_codigo, r_entrada} <= w_firstWord;
              r_pc                  <= (AW + 1)'(1);
            end else begin
              r_state   <= S_FIN_RD;
              r_codigo  <= 3'b011;
              r_entrada <= 8'd0;
            end
          end
          S_RUN: begin
            if (r_pc == r_len) begin
              r_state   <= S_FIN_RD;
              r_codigo  <= 3'b011;
              r_entrada <= 8'd0;
            end else begin
              {r_codigo, r_entrada} <= w_pcWord;
              r_pc                  <= r_pc + (AW + 1)'(1);
            end
          end
          S_FIN_RD: begin
            r_state   <= S_FIN_WT;
            r_codigo  <= 3'b111;
            r_entrada <= 8'd0;
          end
          S_FIN_WT: begin
            r_state   <= S_DONE;
            r_result  <= bus.calc_saida;
            r_done    <= 1'b1;
            r_codigo  <= 3'b000;
            r_entrada <= 8'd0;
          end
          S_DONE: begin
            r_state   <= S_IDLE;
            r_codigo  <= 3'b000;
            r_entrada <= 8'd0;
          end
          default: begin
            r_state   <= S_IDLE;
            r_codigo  <= 3'b000;
            r_entrada <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.calc_codigo  = r_codigo;
  assign bus.calc_entrada = r_entrada;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;
  assign bus.result       = r_result;
endmodule

// File: tb/tb_calc_sequenciador.sv
// Randomised self-checking bench for calc_sequenciador, with a behavioural
// calculator attached and an arithmetic reference model of the program result.
module tb_calc_sequenciador;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [10:0] tbMem [16];
  logic [7:0]  modelAcc;
  logic [7:0]  lastResult;
  logic [7:0]  calcAcc;

  calc_sequenciador_if #(.AW(4)) ifc ();

  calc_sequenciador #(.AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator: registered saida, arithmetic mod 256, ops 100-111 hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      calcAcc        <= 8'd0;
      ifc.calc_saida <= 8'd0;
    end else begin
      case (ifc.calc_codigo)
        3'b000: ifc.calc_saida <= ifc.calc_entrada;
        3'b001: begin
          calcAcc        <= calcAcc + ifc.calc_entrada;
          ifc.calc_saida <= calcAcc + ifc.calc_entrada;
        end
        3'b010: begin
          calcAcc        <= calcAcc - ifc.calc_entrada;
          ifc.calc_saida <= calcAcc - ifc.calc_entrada;
        end
        3'b011: ifc.calc_saida <= calcAcc;
        default: ;
      endcase
    end
  end

  task automatic writeWord(input int addr, input logic [10:0] data);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = 4'(addr);
    ifc.wr_data = data;
    @(posedge clk); #1;
    ifc.wr_en   = 1'b0;
    tbMem[addr] = data;
  endtask

  // Runs one sequence and checks clear codes, replayed words, busy, done timing and result.
  // injK > 0 pokes wr_en/start while busy at that cycle offset.
  task automatic runSeq(input int n, input bit c, input bit withAbort, input int injK, input string tag);
    int         nEff;
    int         expDone;
    int         runStart;
    int         doneAt;
    logic [7:0] acc;
    logic [7:0] preClr;
    nEff    = (n > 16) ? 16 : n;
    preClr  = modelAcc;
    acc     = c ? 8'd0 : modelAcc;
    for (int i = 0; i < nEff; i++) begin
      case (tbMem[i][10:8])
        3'b001:  acc = acc + tbMem[i][7:0];
        3'b010:  acc = acc - tbMem[i][7:0];
        default: ;
      endcase
    end
    expDone  = (c ? 6 : 3) + nEff;
    runStart = c ? 4 : 1;
    doneAt   = 0;
    ifc.start = 1'b1;
    ifc.len   = 5'(n);
    ifc.clr   = c;
    ifc.abort = withAbort;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifc.clr   = 1'b0;
        ifc.len   = 5'd0;
      end
      if (injK > 0 && k == injK) begin
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 4'd0;
        ifc.wr_data = {3'b010, 8'd99};
        ifc.start   = 1'b1;
        ifc.len     = 5'd0;
      end
      if (injK > 0 && k == injK + 1) begin
        ifc.wr_en = 1'b0;
        ifc.start = 1'b0;
      end
      if (c && k == 1) begin
        checks++;
        if (ifc.calc_codigo !== 3'b011) begin
          errors++;
          $display("[TB] FAIL %s clr_rd codigo got %b want 011", tag, ifc.calc_codigo);
        end
      end
      if (c && k == 2) begin
        checks++;
        if (ifc.calc_codigo !== 3'b111) begin
          errors++;
          $display("[TB] FAIL %s clr_wt codigo got %b want 111", tag, ifc.calc_codigo);
        end
      end
      if (c && k == 3) begin
        checks++;
        if (ifc.calc_codigo !== 3'b010 || ifc.calc_entrada !== preClr) begin
          errors++;
          $display("[TB] FAIL %s clr_sub got %b/%0d want 010/%0d", tag, ifc.calc_codigo, ifc.calc_entrada, preClr);
        end
      end
      if (k >= runStart && k < runStart + nEff) begin
        checks++;
        if ({ifc.calc_codigo, ifc.calc_entrada} !== tbMem[k - runStart]) begin
          errors++;
          $display("[TB] FAIL %s run word %0d got %h want %h", tag, k - runStart,
                   {ifc.calc_codigo, ifc.calc_entrada}, tbMem[k - runStart]);
        end
      end
      if (k == runStart + nEff) begin
        checks++;
        if (ifc.calc_codigo !== 3'b011) begin
          errors++;
          $display("[TB] FAIL %s fin_rd codigo got %b want 011", tag, ifc.calc_codigo);
        end
      end
      if (k <= expDone) begin
        checks++;
        if (ifc.busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s busy at s+%0d got %b want 1", tag, k, ifc.busy);
        end
      end
      if (ifc.done === 1'b1 && doneAt == 0) doneAt = k;
      if (k == expDone) begin
        checks++;
        if (ifc.done !== 1'b1 || ifc.result !== acc) begin
          errors++;
          $display("[TB] FAIL %s done/result at s+%0d got %b/%0d want 1/%0d", tag, k, ifc.done, ifc.result, acc);
        end
      end
      if (k == expDone + 1) begin
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.result !== acc) begin
          errors++;
          $display("[TB] FAIL %s after done busy/done/result got %b/%b/%0d want 0/0/%0d",
                   tag, ifc.busy, ifc.done, ifc.result, acc);
        end
        break;
      end
    end
    checks++;
    if (doneAt != expDone) begin
      errors++;
      $display("[TB] FAIL %s done cycle got s+%0d want s+%0d", tag, doneAt, expDone);
    end
    modelAcc   = acc;
    lastResult = acc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ifc.calc_codigo !== 3'b000 || ifc.calc_entrada !== 8'd0 || ifc.busy !== 1'b0 ||
        ifc.done !== 1'b0 || ifc.result !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %b/%0d/%b/%b/%0d want 000/0/0/0/0",
               ifc.calc_codigo, ifc.calc_entrada, ifc.busy, ifc.done, ifc.result);
    end
    rst = 1'b0;
    modelAcc   = 8'd0;
    lastResult = 8'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_program_basic();
    writeWord(0, {3'b001, 8'd10});
    writeWord(1, {3'b001, 8'd20});
    writeWord(2, {3'b010, 8'd5});
    runSeq(3, 1'b1, 1'b0, 0, "plan1");
    writeWord(0, {3'b001, 8'd250});
    runSeq(1, 1'b0, 1'b0, 0, "plan2");
    writeWord(0, {3'b010, 8'd20});
    runSeq(1, 1'b1, 1'b0, 0, "plan3");
    checks++;
    if (lastResult !== 8'd236 || ifc.result !== 8'd236) begin
      errors++;
      $display("[TB] FAIL plan3 result got %0d want 236", ifc.result);
    end
  endtask

  task automatic test_noop_full();
    for (int i = 0; i < 16; i++) writeWord(i, {3'b001, 8'd1});
    writeWord(8, {3'b111, 8'h5A});
    runSeq(16, 1'b1, 1'b0, 0, "noop16");
    runSeq(0, 1'b0, 1'b0, 0, "len0");
  endtask

  task automatic test_abort();
    writeWord(8, {3'b001, 8'd1});
    ifc.start = 1'b1;
    ifc.len   = 5'd16;
    ifc.clr   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ifc.start = 1'b0;
        ifc.clr   = 1'b0;
        ifc.len   = 5'd0;
      end
    end
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.calc_codigo !== 3'b000 || ifc.calc_entrada !== 8'd0 ||
        ifc.done !== 1'b0 || ifc.result !== lastResult) begin
      errors++;
      $display("[TB] FAIL abort outputs got %b/%b/%0d/%b/%0d want 0/000/0/0/%0d",
               ifc.busy, ifc.calc_codigo, ifc.calc_entrada, ifc.done, ifc.result, lastResult);
    end
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort quiet done/busy got %b/%b want 0/0", ifc.done, ifc.busy);
      end
    end
    modelAcc = 8'd5;
    runSeq(0, 1'b0, 1'b0, 0, "abort_rb");
  endtask

  task automatic test_abort_idle();
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.result !== lastResult) begin
      errors++;
      $display("[TB] FAIL abort_idle got %b/%b/%0d want 0/0/%0d", ifc.busy, ifc.done, ifc.result, lastResult);
    end
    writeWord(0, {3'b001, 8'd3});
    writeWord(1, {3'b010, 8'd1});
    writeWord(2, {3'b000, 8'd77});
    writeWord(3, {3'b001, 8'd40});
    runSeq(4, 1'b0, 1'b1, 0, "start_abort");
  endtask

  task automatic test_busy_ignore();
    writeWord(0, {3'b001, 8'd7});
    writeWord(1, {3'b001, 8'd9});
    runSeq(2, 1'b1, 1'b0, 5, "busy_ign");
    runSeq(2, 1'b1, 1'b0, 0, "busy_ign_rb");
  endtask

  task automatic test_rst_midrun();
    ifc.start = 1'b1;
    ifc.len   = 5'd16;
    ifc.clr   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ifc.start = 1'b0;
        ifc.len   = 5'd0;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.calc_codigo !== 3'b000 || ifc.calc_entrada !== 8'd0 || ifc.busy !== 1'b0 ||
        ifc.done !== 1'b0 || ifc.result !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rst_midrun got %b/%0d/%b/%b/%0d want 000/0/0/0/0",
               ifc.calc_codigo, ifc.calc_entrada, ifc.busy, ifc.done, ifc.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    modelAcc   = 8'd0;
    lastResult = 8'd0;
    runSeq(5, 1'b0, 1'b0, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n;
      for (int i = 0; i < 16; i++) writeWord(i, 11'($urandom));
      n = (it == 3 || it == 9) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      runSeq(n, 1'($urandom_range(0, 1)), 1'b0, 0, $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    ifc.wr_en   = 1'b0;
    ifc.wr_addr = 4'd0;
    ifc.wr_data = 11'd0;
    ifc.start   = 1'b0;
    ifc.len     = 5'd0;
    ifc.clr     = 1'b0;
    ifc.abort   = 1'b0;
    for (int i = 0; i < 16; i++) tbMem[i] = 11'd0;
    test_reset();
    test_program_basic();
    test_noop_full();
    test_abort();
    test_abort_idle();
    test_busy_ignore();
    test_rst_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
